// File: rtl/shift_seq_pkg.sv
// Shared types and register select encodings for the shift sequencer and the
// universal shift register it drives.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

endpackage

// File: rtl/shift_sequencer.sv
// Loads a word into the downstream universal shift register, shifts it out WIDTH
// times and reassembles the serial stream, giving an end-to-end loopback result.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter logic        FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_dir,
  input  logic             hold,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] par_out,
  output logic             si_out,
  input  logic             so_in,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] rx_q, rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    dir_d   = dir_q;
    rx_d    = rx_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          data_d  = tx_data;
          dir_d   = tx_dir;
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = '0;
        rx_d    = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (!hold) begin
          // so_in is the bit leaving the register on this edge
          rx_d    = dir_q ? {so_in, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], so_in};
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (rx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are forced idle while rst is high, whatever the current state.
  always_comb begin
    sel      = SEL_HOLD;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    busy     = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        IDLE:    tx_ready = 1'b1;
        LOAD:    sel = SEL_LOAD;
        SHIFT:   sel = hold ? SEL_HOLD : (dir_q ? SEL_RIGHT : SEL_LEFT);
        DONE:    rx_valid = 1'b1;
        default: sel = SEL_HOLD;
      endcase
    end
  end

  assign par_out = data_q;
  assign si_out  = FILL;
  assign rx_data = rx_q;

endmodule
